// File: rtl/memory_game_pkg.sv
// Shared constants and state encoding for the memorization-game round sequencer.
package memory_game_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;
   localparam int BCD_MAX = 9;
   localparam int CODE_W  = DIGITS * DIGIT_W;
   localparam int CNT_W   = $clog2(DIGITS + 1);

   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
   localparam logic [2:0] ST_SHOW_ENC  = 3'd2;
   localparam logic [2:0] ST_ENTRY_ENC = 3'd3;
   localparam logic [2:0] ST_CHECK_ENC = 3'd4;
   localparam logic [2:0] ST_WIN_ENC   = 3'd5;
   localparam logic [2:0] ST_LOSE_ENC  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_LOAD  = ST_LOAD_ENC,
      ST_SHOW  = ST_SHOW_ENC,
      ST_ENTRY = ST_ENTRY_ENC,
      ST_CHECK = ST_CHECK_ENC,
      ST_WIN   = ST_WIN_ENC,
      ST_LOSE  = ST_LOSE_ENC
   } state_e;

endpackage

// File: rtl/digit_entry_shreg.sv
// Collects up to DIGITS BCD digits into a right-aligned shift register; non-BCD digits are dropped.
module digit_entry_shreg
   import memory_game_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               valid,
   output logic [CODE_W-1:0]  value,
   output logic [CNT_W-1:0]   count
);

   logic [CODE_W-1:0] value_q, value_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              accept;

   always_comb begin
      accept  = en && valid && (digit <= DIGIT_W'(BCD_MAX)) && (count_q < CNT_W'(DIGITS));
      value_d = value_q;
      count_d = count_q;
      if (clr) begin
         value_d = '0;
         count_d = '0;
      end else if (accept) begin
         value_d = {value_q[CODE_W-DIGIT_W-1:0], digit};
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value = value_q;
   assign count = count_q;

endmodule

// File: rtl/memory_game_ctrl.sv
// Round sequencer: capture code, show it, collect 4 digits, report win/lose, track score.
// Optional entry timeout is built when ENTRY_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture code, clear entry, load show timer
// SHOW  | code displayed for show_len cycles
// ENTRY | accepting user digits
// CHECK | compare entry against captured code
// WIN   | win held RESULT_CYCLES, then next round
// LOSE  | lose held RESULT_CYCLES, then IDLE
module memory_game_ctrl
   import memory_game_pkg::*;
#(
   parameter int SHOW_CYCLES    = 64,
   parameter int SHOW_STEP      = 8,
   parameter int SHOW_MIN       = 16,
   parameter int RESULT_CYCLES  = 32,
   parameter int SCORE_W        = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [15:0]        rand_int,
   input  logic [3:0]         digit_in,
   input  logic               digit_valid,
   output logic               show_en,
   output logic [15:0]        show_value,
   output logic [15:0]        entry_value,
   output logic [2:0]         digits_entered,
   output logic               win,
   output logic               lose,
   output logic [SCORE_W-1:0] score,
   output logic               busy
);

   localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
   localparam int RES_W  = $clog2(RESULT_CYCLES + 1);

   state_e             state_q, state_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [SHOW_W-1:0]  show_len_q, show_len_d;
   logic [SHOW_W-1:0]  show_cnt_q, show_cnt_d;
   logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;

   logic               entry_clr;
   logic               entry_en;
   logic [CODE_W-1:0]  entry_val;
   logic [CNT_W-1:0]   entry_cnt;
   logic               digit_acc;
   logic               go_win;
   logic               go_lose;

`ifdef ENTRY_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

   assign entry_en  = (state_q == ST_ENTRY);
   assign digit_acc = entry_en && digit_valid && (digit_in <= DIGIT_W'(BCD_MAX))
                      && (entry_cnt < CNT_W'(DIGITS));

   digit_entry_shreg u_entry (
      .clk   (clk),
      .rst   (rst),
      .clr   (entry_clr),
      .en    (entry_en),
      .digit (digit_in),
      .valid (digit_valid),
      .value (entry_val),
      .count (entry_cnt)
   );

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      show_len_d = show_len_q;
      show_cnt_d = show_cnt_q;
      res_cnt_d  = res_cnt_q;
      score_d    = score_q;
      entry_clr  = 1'b0;
      go_win     = 1'b0;
      go_lose    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            code_d     = rand_int;
            entry_clr  = 1'b1;
            show_cnt_d = show_len_q;
            state_d    = ST_SHOW;
`ifdef ENTRY_TIMEOUT_EN
            tmo_d      = '0;
`endif
         end
         ST_SHOW: begin
            if (show_cnt_q == SHOW_W'(1)) state_d = ST_ENTRY;
            else                          show_cnt_d = show_cnt_q - SHOW_W'(1);
         end
         ST_ENTRY: begin
            if (digit_acc && (entry_cnt == CNT_W'(DIGITS - 1))) state_d = ST_CHECK;
`ifdef ENTRY_TIMEOUT_EN
            if (digit_acc)                                tmo_d   = '0;
            else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) go_lose = 1'b1;
            else                                          tmo_d   = tmo_q + TMO_W'(1);
`endif
         end
         ST_CHECK: begin
            if (entry_val == code_q) go_win  = 1'b1;
            else                     go_lose = 1'b1;
         end
         ST_WIN: begin
            if (res_cnt_q == RES_W'(1)) state_d = ST_LOAD;
            else                        res_cnt_d = res_cnt_q - RES_W'(1);
         end
         ST_LOSE: begin
            if (res_cnt_q == RES_W'(1)) state_d = ST_IDLE;
            else                        res_cnt_d = res_cnt_q - RES_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Result-entry side effects are shared by the CHECK path and the entry timeout.
      if (go_win) begin
         state_d   = ST_WIN;
         res_cnt_d = RES_W'(RESULT_CYCLES);
         if (score_q != '1) score_d = score_q + SCORE_W'(1);
         if (32'(show_len_q) >= 32'(SHOW_MIN + SHOW_STEP))
            show_len_d = show_len_q - SHOW_W'(SHOW_STEP);
         else
            show_len_d = SHOW_W'(SHOW_MIN);
      end
      if (go_lose) begin
         state_d    = ST_LOSE;
         res_cnt_d  = RES_W'(RESULT_CYCLES);
         score_d    = '0;
         show_len_d = SHOW_W'(SHOW_CYCLES);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         code_q     <= '0;
         show_len_q <= SHOW_W'(SHOW_CYCLES);
         show_cnt_q <= '0;
         res_cnt_q  <= '0;
         score_q    <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         show_len_q <= show_len_d;
         show_cnt_q <= show_cnt_d;
         res_cnt_q  <= res_cnt_d;
         score_q    <= score_d;
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   assign show_en        = (state_q == ST_SHOW);
   assign show_value     = show_en ? code_q : '0;
   assign entry_value    = entry_val;
   assign digits_entered = entry_cnt;
   assign win            = (state_q == ST_WIN);
   assign lose           = (state_q == ST_LOSE);
   assign score          = score_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: round table, saturation run, filter/reset/timeout sequences.
module tb_memory_game_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] rand_int;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        show_en;
   logic [15:0] show_value;
   logic [15:0] entry_value;
   logic [2:0]  digits_entered;
   logic        win;
   logic        lose;
   logic [7:0]  score;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   memory_game_ctrl #(
      .SHOW_CYCLES    (8),
      .SHOW_STEP      (2),
      .SHOW_MIN       (4),
      .RESULT_CYCLES  (3),
      .SCORE_W        (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .rand_int       (rand_int),
      .digit_in       (digit_in),
      .digit_valid    (digit_valid),
      .show_en        (show_en),
      .show_value     (show_value),
      .entry_value    (entry_value),
      .digits_entered (digits_entered),
      .win            (win),
      .lose           (lose),
      .score          (score),
      .busy           (busy)
   );

   typedef struct {
      logic [15:0] code;
      logic [15:0] entry;
      int          exp_len;
      bit          exp_win;
      int          exp_score;
   } round_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_show_done();
      int n;
      n = 0;
      while (!show_en && n < 20) begin step(); n++; end
      check("show_seen", show_en, 1);
      n = 0;
      while (show_en && n < 40) begin step(); n++; end
   endtask

   task automatic enter_digit(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic play_round(input logic [15:0] code, input logic [15:0] entry,
                             input int exp_len, input bit exp_win, input int exp_score);
      int n;
      rand_int = code;
      if (!busy) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      n = 0;
      while (!show_en && n < 20) begin step(); n++; end
      check("show_start", show_en, 1);
      check("show_value", show_value, code);
      n = 0;
      while (show_en && n < 40) begin step(); n++; end
      check("show_len", n, exp_len);
      check("show_value_off", show_value, 0);
      for (int i = 3; i >= 0; i--) enter_digit(entry[i*4 +: 4]);
      check("digits_entered", digits_entered, 4);
      check("entry_value", entry_value, entry);
      step();
      n = 0;
      while ((exp_win ? win : lose) && n < 10) begin
         check("other_flag", exp_win ? lose : win, 0);
         step();
         n++;
      end
      check("hold_len", n, 3);
      check("score", score, exp_score);
      check("busy_after", busy, exp_win);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      round_t rounds[7];
      int     exp_sc;
      int     seen;

      rounds[0] = '{16'h1234, 16'h1234, 8, 1'b1, 1};
      rounds[1] = '{16'h5678, 16'h5678, 6, 1'b1, 2};
      rounds[2] = '{16'h0000, 16'h0000, 4, 1'b1, 3};
      rounds[3] = '{16'h9999, 16'h9999, 4, 1'b1, 4};
      rounds[4] = '{16'h9087, 16'h9086, 4, 1'b0, 0};
      rounds[5] = '{16'h4321, 16'h4321, 8, 1'b1, 1};
      rounds[6] = '{16'h1111, 16'h2111, 6, 1'b0, 0};

      rst = 1'b1; start = 1'b0; rand_int = '0; digit_in = '0; digit_valid = 1'b0;
      step(); step();
      check("rst_show_en", show_en, 0);
      check("rst_show_value", show_value, 0);
      check("rst_entry_value", entry_value, 0);
      check("rst_digits", digits_entered, 0);
      check("rst_win", win, 0);
      check("rst_lose", lose, 0);
      check("rst_score", score, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      step();
      check("idle_busy", busy, 0);

      for (int r = 0; r < 7; r++)
         play_round(rounds[r].code, rounds[r].entry, rounds[r].exp_len,
                    rounds[r].exp_win, rounds[r].exp_score);

      // Score saturation: 256 straight wins from score 0.
      exp_sc = 0;
      for (int k = 0; k < 256; k++) begin
         exp_sc = (exp_sc == 255) ? 255 : exp_sc + 1;
         play_round(16'h0505, 16'h0505, (k == 0) ? 8 : (k == 1) ? 6 : 4, 1'b1, exp_sc);
      end
      check("sat_score", score, 8'hFF);
      play_round(16'h3333, 16'h3334, 4, 1'b0, 0);

      // Filtering: digits during SHOW, non-BCD digits and start during ENTRY.
      rand_int = 16'h2468;
      start = 1'b1; step(); start = 1'b0;
      step();
      check("flt_in_show", show_en, 1);
      digit_in = 4'd2; digit_valid = 1'b1;
      step(); step(); step();
      digit_valid = 1'b0;
      check("flt_show_digits", digits_entered, 0);
      check("flt_still_show", show_en, 1);
      wait_show_done();
      enter_digit(4'hA);
      check("flt_digit_a", digits_entered, 0);
      start = 1'b1; step(); start = 1'b0;
      check("flt_start_digits", digits_entered, 0);
      check("flt_start_busy", busy, 1);
      check("flt_start_show", show_en, 0);
      enter_digit(4'd2);
      check("flt_first", digits_entered, 1);
      enter_digit(4'hF);
      check("flt_digit_f", digits_entered, 1);
      enter_digit(4'd4);
      enter_digit(4'd6);
      enter_digit(4'd8);
      check("flt_entry", entry_value, 16'h2468);
      step();
      check("flt_win", win, 1);
      seen = 0;
      while (win && seen < 10) begin step(); seen++; end
      check("flt_score", score, 1);

      // Reset in the middle of ENTRY after two digits.
      rand_int = 16'h1357;
      wait_show_done();
      enter_digit(4'd1);
      enter_digit(4'd3);
      check("rm_digits", digits_entered, 2);
      rst = 1'b1; step(); rst = 1'b0;
      check("rm_busy", busy, 0);
      check("rm_show_en", show_en, 0);
      check("rm_show_value", show_value, 0);
      check("rm_entry", entry_value, 0);
      check("rm_digits0", digits_entered, 0);
      check("rm_win", win, 0);
      check("rm_lose", lose, 0);
      check("rm_score", score, 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (win || lose || busy) seen++;
         step();
      end
      check("rm_quiet", seen, 0);
      play_round(16'h1357, 16'h1357, 8, 1'b1, 1);

      // Entry timeout: one digit then silence.
      rand_int = 16'h2222;
      wait_show_done();
      enter_digit(4'd2);
      check("tmo_digits", digits_entered, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (lose) seen = 1;
         step();
      end
`ifdef ENTRY_TIMEOUT_EN
      check("tmo_lose", seen, 1);
      check("tmo_score", score, 0);
`else
      check("tmo_no_lose", seen, 0);
      check("tmo_busy", busy, 1);
      check("tmo_wait_digits", digits_entered, 1);
`endif
      rst = 1'b1; step(); rst = 1'b0;
      check("end_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
